// File: rtl/lcd_dispctl_tx.sv
`default_nettype none
// ============================================================================
// Module      : lcd_dispctl_tx
// Description : Sends the HD44780 "Display ON/OFF control" command (0000_1DCB)
//               over the 4-bit LCD bus when the cursor/blink word changes.
//               Optional periodic resend: define LCD_DISPCTL_REFRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_dispctl_tx #(
    parameter int T_SETUP        = 2,
    parameter int T_PULSE        = 12,
    parameter int T_HOLD         = 1,
    parameter int T_GAP          = 50,
    parameter int T_WAIT         = 2000,
    parameter int REFRESH_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] blink_in,
    input  logic       init_done,
    output logic [3:0] lcd_d,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       busy,
    output logic       cmd_sent
);

    localparam int c_MAX_A  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int c_MAX_B  = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int c_MAX_C  = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_MAX_T  = (c_MAX_C > T_WAIT) ? c_MAX_C : T_WAIT;
    localparam int c_CW_RAW = $clog2(c_MAX_T);
    localparam int c_CNT_W  = (c_CW_RAW < 12) ? 12 : c_CW_RAW;

    localparam logic [c_CNT_W-1:0] c_LD_SETUP = c_CNT_W'(T_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_LD_PULSE = c_CNT_W'(T_PULSE - 1);
    localparam logic [c_CNT_W-1:0] c_LD_HOLD  = c_CNT_W'(T_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_LD_GAP   = c_CNT_W'(T_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_LD_WAIT  = c_CNT_W'(T_WAIT - 1);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_HI_SETUP = 4'd1;
    localparam logic [3:0] c_HI_PULSE = 4'd2;
    localparam logic [3:0] c_HI_HOLD  = 4'd3;
    localparam logic [3:0] c_GAP      = 4'd4;
    localparam logic [3:0] c_LO_SETUP = 4'd5;
    localparam logic [3:0] c_LO_PULSE = 4'd6;
    localparam logic [3:0] c_LO_HOLD  = 4'd7;
    localparam logic [3:0] c_WAIT     = 4'd8;

    logic [3:0]         r_state;
    logic [3:0]         w_state_nx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nx;
    logic [1:0]         r_blink_s;
    logic [1:0]         r_last_sent;
    logic [3:0]         r_cmd_lo;
    logic [7:0]         w_cmd;
    logic               w_start;
    logic               w_refresh_req;
    logic [3:0]         r_lcd_d;
    logic               r_lcd_e;
    logic               r_busy;
    logic               r_cmd_sent;

    assign w_cmd = {4'b0000, 2'b11, r_blink_s};

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_start    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (init_done && ((r_blink_s != r_last_sent) || w_refresh_req)) begin
                    w_start    = 1'b1;
                    w_state_nx = c_HI_SETUP;
                    w_cnt_nx   = c_LD_SETUP;
                end
            end
            default: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - c_CNT_W'(1);
                end else begin
                    case (r_state)
                        c_HI_SETUP: begin w_state_nx = c_HI_PULSE; w_cnt_nx = c_LD_PULSE; end
                        c_HI_PULSE: begin w_state_nx = c_HI_HOLD;  w_cnt_nx = c_LD_HOLD;  end
                        c_HI_HOLD:  begin w_state_nx = c_GAP;      w_cnt_nx = c_LD_GAP;   end
                        c_GAP:      begin w_state_nx = c_LO_SETUP; w_cnt_nx = c_LD_SETUP; end
                        c_LO_SETUP: begin w_state_nx = c_LO_PULSE; w_cnt_nx = c_LD_PULSE; end
                        c_LO_PULSE: begin w_state_nx = c_LO_HOLD;  w_cnt_nx = c_LD_HOLD;  end
                        c_LO_HOLD:  begin w_state_nx = c_WAIT;     w_cnt_nx = c_LD_WAIT;  end
                        default:    begin w_state_nx = c_IDLE;     w_cnt_nx = '0;         end
                    endcase
                end
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up
    // exactly with the state dwell windows and cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_blink_s   <= 2'b00;
            r_last_sent <= 2'b00;
            r_cmd_lo    <= 4'b0000;
            r_lcd_d     <= 4'b0000;
            r_lcd_e     <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_sent  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_blink_s  <= blink_in;
            r_busy     <= (w_state_nx != c_IDLE);
            r_lcd_e    <= (w_state_nx == c_HI_PULSE) || (w_state_nx == c_LO_PULSE);
            r_cmd_sent <= (w_state_nx == c_WAIT) && (w_cnt_nx == '0);
            if (w_start) begin
                r_cmd_lo    <= w_cmd[3:0];
                r_last_sent <= r_blink_s;
                r_lcd_d     <= w_cmd[7:4];
            end else if ((w_state_nx == c_GAP) && (r_state != c_GAP)) begin
                r_lcd_d <= r_cmd_lo;
            end
        end
    end

`ifdef LCD_DISPCTL_REFRESH_EN
    localparam int c_REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [c_REF_W-1:0] r_ref_cnt;
    logic               r_ref_req;

    // A tick landing on the start cycle wins so no refresh period is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt <= '0;
            r_ref_req <= 1'b0;
        end else begin
            if (w_start) begin
                r_ref_req <= 1'b0;
            end
            if (!init_done) begin
                r_ref_cnt <= '0;
            end else if (r_ref_cnt == c_REF_W'(REFRESH_CYCLES - 1)) begin
                r_ref_cnt <= '0;
                r_ref_req <= 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt + c_REF_W'(1);
            end
        end
    end

    assign w_refresh_req = r_ref_req;
`else
    logic w_unused_refresh;
    assign w_unused_refresh = (REFRESH_CYCLES > 0);
    assign w_refresh_req    = 1'b0;
`endif

    assign lcd_d    = r_lcd_d;
    assign lcd_e    = r_lcd_e;
    assign lcd_rs   = 1'b0;
    assign lcd_rw   = 1'b0;
    assign busy     = r_busy;
    assign cmd_sent = r_cmd_sent;

endmodule
`default_nettype wire

// File: tb/tb_lcd_dispctl_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_dispctl_tx
// Description : Self-checking bench for lcd_dispctl_tx against a timeline
//               model of one 2080-cycle command transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_dispctl_tx;

    localparam int c_BUSY_LEN = 2080;

    logic       clk;
    logic       rst_n;
    logic [1:0] blink_in;
    logic       init_done;
    logic [3:0] lcd_d;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       busy;
    logic       cmd_sent;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: m_t is the cycle index inside the current transaction, 0 = idle.
    int         m_t       = 0;
    logic [1:0] m_blink_s = 2'b00;
    logic [1:0] m_last    = 2'b00;
    logic [3:0] m_lo      = 4'h0;

    lcd_dispctl_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blink_in  (blink_in),
        .init_done (init_done),
        .lcd_d     (lcd_d),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .busy      (busy),
        .cmd_sent  (cmd_sent)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Timeline of one transaction: setup 1-2, E 3-14, hold 15, gap 16-65,
    // setup 66-67, E 68-79, hold 80, wait 81-2080.
    task automatic tick();
        logic exp_e;
        @(posedge clk);
        if (m_t == 0) begin
            if (init_done && (m_blink_s != m_last)) begin
                m_lo   = {2'b11, m_blink_s};
                m_last = m_blink_s;
                m_t    = 1;
            end
        end else if (m_t == c_BUSY_LEN) begin
            m_t = 0;
        end else begin
            m_t++;
        end
        m_blink_s = blink_in;
        @(negedge clk);
        exp_e = ((m_t >= 3) && (m_t <= 14)) || ((m_t >= 68) && (m_t <= 79));
        chk("ctl{busy,e,sent,rs,rw}", {27'd0, busy, lcd_e, cmd_sent, lcd_rs, lcd_rw},
            {27'd0, (m_t != 0), exp_e, (m_t == c_BUSY_LEN), 2'b00});
        if ((m_t >= 1) && (m_t <= 15))
            chk("d_hi", {28'd0, lcd_d}, 32'h0);
        else if ((m_t >= 16) && (m_t <= 80))
            chk("d_lo", {28'd0, lcd_d}, {28'd0, m_lo});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int k;
        int hold;
        rst_n     = 1'b0;
        blink_in  = 2'b00;
        init_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {27'd0, busy, lcd_e, cmd_sent, lcd_rs, lcd_rw}, 32'd0);
        chk("rst_d", {28'd0, lcd_d}, 32'd0);
        rst_n = 1'b1;

        // First command after reset: nibbles 0 then F.
        init_done = 1'b1;
        blink_in  = 2'b11;
        run(2300);

        // Held off by init_done, then one command with low nibble E.
        init_done = 1'b0;
        blink_in  = 2'b10;
        run(1000);
        init_done = 1'b1;
        run(2300);

        // Changes during a transaction: 11 completes, then a single C.
        blink_in = 2'b11;
        run(200);
        blink_in = 2'b01;
        run(300);
        blink_in = 2'b00;
        run(4600);

        // One-cycle sampled glitch: D then C.
        blink_in = 2'b01;
        run(1);
        blink_in = 2'b00;
        run(4500);

        // Reset during the low-nibble E pulse.
        blink_in = 2'b11;
        k = 0;
        while ((m_t != 70) && (k < 3000)) begin
            tick();
            k++;
        end
        chk("reach_lo_pulse", {31'd0, (m_t == 70)}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst{e,busy,sent}", {29'd0, lcd_e, busy, cmd_sent}, 32'd0);
        m_t       = 0;
        m_last    = 2'b00;
        m_blink_s = 2'b00;
        blink_in  = 2'b01;
        @(posedge clk);
        @(negedge clk);
        chk("in_rst_d", {28'd0, lcd_d}, 32'd0);
        rst_n = 1'b1;
        run(2300);

        // Randomized blink words, hold times and init_done drops.
        for (int i = 0; i < 40; i++) begin
            blink_in  = 2'($urandom_range(0, 3));
            init_done = ($urandom_range(0, 9) != 0);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(50, 1500);
            run(hold);
        end
        init_done = 1'b1;
        run(4300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
